// File: rtl/image_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// image_ram_arbiter_pkg
// Purpose : Shared definitions for the image RAM arbiter and the CPU-side MMIO
//           decode: bit positions of the 32-bit CPU command word, the layout
//           of a queued command entry, and the arbiter FSM state encodings.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package image_ram_arbiter_pkg;

    // CPU command word: {7'b0, fill, wEn, data[7:0], addr[14:0]}
    localparam int CMD_FILL    = 24;
    localparam int CMD_WEN     = 23;
    localparam int CMD_DATA_HI = 22;
    localparam int CMD_DATA_LO = 15;
    localparam int CMD_ADDR_HI = 14;
    localparam int CMD_ADDR_LO = 0;

    // Arbiter FSM encodings, kept as plain constants so older decode logic can
    // compare against them directly.
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_FILL = 1'b1;

    // One pending command as held in the FIFO. For a fill entry the data field
    // carries the fill colour and the address field is ignored.
    typedef struct packed {
        logic        fill;
        logic [7:0]  data;
        logic [14:0] addr;
    } cmd_entry_t;

    // Extract the queued form of a command from the raw CPU word.
    function automatic cmd_entry_t decode_cmd(input logic [31:0] word);
        cmd_entry_t entry;
        entry.fill = word[CMD_FILL];
        entry.data = word[CMD_DATA_HI:CMD_DATA_LO];
        entry.addr = word[CMD_ADDR_HI:CMD_ADDR_LO];
        return entry;
    endfunction

    // A word only does something if it asks for a write or a fill.
    function automatic logic is_command(input logic [31:0] word);
        return word[CMD_WEN] | word[CMD_FILL];
    endfunction

endpackage

// File: rtl/image_cmd_fifo.sv
// ---------------------------------------------------------------------------
// image_cmd_fifo
// Purpose : Small synchronous FIFO holding pending CPU commands. The head entry
//           is visible combinationally (first-word fall-through) so the
//           arbiter can decide on it and pop in the same cycle.
// Ports   : clk, reset (async, active-high)
//           push, push_data  - enqueue, ignored when full
//           pop              - dequeue, ignored when empty
//           head             - oldest entry (valid when !empty)
//           full, empty, count
// ---------------------------------------------------------------------------
module image_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks
    // occupancy so full and empty never need pointer comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/image_ram_arbiter.sv
// ---------------------------------------------------------------------------
// image_ram_arbiter
// Purpose : Shares the single-port image RAM between CPU pixel writes / screen
//           fills and the VGA scan-out reads. Commands are queued and only
//           reach the RAM while the display is blanking; during the visible
//           region the display read owns the port every cycle.
// Ports   : clk, reset (async, active-high)
//           cpu_word, cpu_valid   - command strobe from the CPU MMIO word
//           cpu_ready             - queue has room
//           vga_active, vga_addr  - display region flag and read address
//           ram_addr, ram_wEn, ram_dataIn - registered RAM port
//           busy                  - commands pending or fill running
//           overflow              - sticky, a command was dropped while full
// ---------------------------------------------------------------------------
module image_ram_arbiter
    import image_ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16384,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_word,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic                     vga_active,
    input  logic [ADDRESS_WIDTH-1:0] vga_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_wEn,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    output logic                     busy,
    output logic                     overflow
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_FILL_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    logic [0:0]                   state;
    logic [ADDRESS_WIDTH-1:0]     fill_addr;
    logic [DATA_WIDTH-1:0]        fill_colour;

    cmd_entry_t                   push_entry;
    cmd_entry_t                   fifo_head;
    logic                         cmd_request;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         unused_word_bits;

    assign unused_word_bits = ^cpu_word[31:25];

    assign push_entry  = decode_cmd(cpu_word);
    assign cmd_request = is_command(cpu_word);
    assign cpu_ready   = !fifo_full;
    assign fifo_push   = cpu_valid && cpu_ready && cmd_request;

    // The head is consumed only in IDLE during blanking; a fill blocks the
    // queue until it finishes so later writes land on top of the fill.
    assign fifo_pop    = (state == STATE_IDLE) && !vga_active && !fifo_empty;

    assign busy        = (fifo_count != '0) || (state == STATE_FILL);

    image_cmd_fifo #(
        .WIDTH (ADDRESS_WIDTH + DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // One RAM access per cycle. Whenever no write is issued the port carries
    // the display address, so scan-out sees a fixed one-cycle latency and an
    // active-region cycle can never carry a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= STATE_IDLE;
            ram_addr    <= '0;
            ram_wEn     <= 1'b0;
            ram_dataIn  <= '0;
            fill_addr   <= '0;
            fill_colour <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (vga_active || fifo_empty) begin
                        ram_addr <= vga_addr;
                        ram_wEn  <= 1'b0;
                    end else if (fifo_head.fill) begin
                        // Starting a fill costs one cycle with no write.
                        fill_colour <= fifo_head.data;
                        fill_addr   <= '0;
                        state       <= STATE_FILL;
                        ram_addr    <= vga_addr;
                        ram_wEn     <= 1'b0;
                    end else begin
                        ram_addr   <= fifo_head.addr;
                        ram_dataIn <= fifo_head.data;
                        ram_wEn    <= 1'b1;
                    end
                end
                STATE_FILL: begin
                    if (vga_active) begin
                        // Pause: fill_addr holds so the fill resumes exactly
                        // where it left off.
                        ram_addr <= vga_addr;
                        ram_wEn  <= 1'b0;
                    end else begin
                        ram_addr   <= fill_addr;
                        ram_dataIn <= fill_colour;
                        ram_wEn    <= 1'b1;
                        if (fill_addr == LAST_FILL_ADDR) begin
                            state <= STATE_IDLE;
                        end else begin
                            fill_addr <= fill_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= STATE_IDLE;
                    ram_wEn <= 1'b0;
                end
            endcase
        end
    end

    // Dropped-command flag; only reset clears it so software can poll it late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cpu_valid && !cpu_ready && cmd_request) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_image_ram_arbiter
// Purpose : Directed self-checking bench for image_ram_arbiter: single write
//           latency, display priority, queue overflow, full-screen fill with
//           trailing write, fill pausing, and reset during a fill.
// ---------------------------------------------------------------------------
module tb_image_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_word;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        vga_active;
    logic [14:0] vga_addr;
    logic [14:0] ram_addr;
    logic        ram_wEn;
    logic [7:0]  ram_dataIn;
    logic        busy;
    logic        overflow;

    int checks;
    int failures;

    image_ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_word   (cpu_word),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .vga_active (vga_active),
        .vga_addr   (vga_addr),
        .ram_addr   (ram_addr),
        .ram_wEn    (ram_wEn),
        .ram_dataIn (ram_dataIn),
        .busy       (busy),
        .overflow   (overflow)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one command for one clock edge.
    task automatic push_cmd(input logic fill, input logic wen,
                            input logic [7:0] data, input logic [14:0] addr);
        cpu_word  = {7'b0, fill, wen, data, addr};
        cpu_valid = 1'b1;
        tick();
        cpu_valid = 1'b0;
        cpu_word  = '0;
    endtask

    initial begin
        int writes;
        int expected_addr;
        logic prev_active;
        logic [14:0] prev_vga_addr;
        logic found;

        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        cpu_word   = '0;
        cpu_valid  = 1'b0;
        vga_active = 1'b0;
        vga_addr   = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_output("reset_ram_addr", 32'(ram_addr), 32'h0);
        check_output("reset_ram_wEn", 32'(ram_wEn), 32'h0);
        check_output("reset_ram_dataIn", 32'(ram_dataIn), 32'h0);
        check_output("reset_overflow", 32'(overflow), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        check_output("reset_cpu_ready", 32'(cpu_ready), 32'h1);
        reset = 1'b0;
        tick();

        // ---------------- 1: single write latency ----------------
        $display("[TB] single write while blanking");
        push_cmd(1'b0, 1'b1, 8'h5A, 15'h0123);
        check_output("t1_wEn_after_push", 32'(ram_wEn), 32'h0);
        check_output("t1_busy_after_push", 32'(busy), 32'h1);
        tick();
        check_output("t1_wEn", 32'(ram_wEn), 32'h1);
        check_output("t1_addr", 32'(ram_addr), 32'h0123);
        check_output("t1_data", 32'(ram_dataIn), 32'h5A);
        check_output("t1_busy_done", 32'(busy), 32'h0);
        tick();
        check_output("t1_wEn_one_cycle", 32'(ram_wEn), 32'h0);

        // Command word with neither wEn nor fill is ignored.
        push_cmd(1'b0, 1'b0, 8'hEE, 15'h0456);
        check_output("t1_noop_busy", 32'(busy), 32'h0);
        tick();
        check_output("t1_noop_wEn", 32'(ram_wEn), 32'h0);

        // ---------------- 2: display priority ----------------
        $display("[TB] writes held off during active region");
        vga_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vga_addr = 15'(16'h0100 + i);
            push_cmd(1'b0, 1'b1, 8'(8'hA0 + i), 15'(16'h0010 + i));
            check_output("t2_read_addr", 32'(ram_addr), 32'(16'h0100 + i));
            check_output("t2_no_write", 32'(ram_wEn), 32'h0);
        end
        vga_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t2_wEn", 32'(ram_wEn), 32'h1);
            check_output("t2_addr", 32'(ram_addr), 32'(16'h0010 + i));
            check_output("t2_data", 32'(ram_dataIn), 32'(8'hA0 + i));
        end
        tick();
        check_output("t2_drained", 32'(ram_wEn), 32'h0);

        // ---------------- 3: overflow ----------------
        $display("[TB] queue overflow");
        vga_active = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'b0, 1'b1, 8'(8'hC0 + i), 15'(16'h0200 + i));
            if (i == 6) check_output("t3_ready_at_7", 32'(cpu_ready), 32'h1);
        end
        check_output("t3_ready_full", 32'(cpu_ready), 32'h0);
        check_output("t3_overflow_before", 32'(overflow), 32'h0);
        push_cmd(1'b0, 1'b1, 8'hFF, 15'h0208);
        check_output("t3_overflow_set", 32'(overflow), 32'h1);
        check_output("t3_no_write", 32'(ram_wEn), 32'h0);
        vga_active = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output("t3_wEn", 32'(ram_wEn), 32'h1);
            check_output("t3_addr", 32'(ram_addr), 32'(16'h0200 + i));
            check_output("t3_data", 32'(ram_dataIn), 32'(8'hC0 + i));
        end
        tick();
        check_output("t3_dropped_not_written", 32'(ram_wEn), 32'h0);
        check_output("t3_overflow_sticky", 32'(overflow), 32'h1);
        check_output("t3_busy_idle", 32'(busy), 32'h0);
        check_output("t3_ready_again", 32'(cpu_ready), 32'h1);

        // ---------------- 4: fill then write ----------------
        $display("[TB] fill followed by queued write");
        vga_active = 1'b1;
        push_cmd(1'b1, 1'b0, 8'h07, 15'h0000);
        push_cmd(1'b0, 1'b1, 8'h33, 15'h0005);
        vga_active = 1'b0;
        tick();
        check_output("t4_fill_start_no_write", 32'(ram_wEn), 32'h0);
        check_output("t4_busy_start", 32'(busy), 32'h1);
        for (int i = 0; i < 16384; i++) begin
            tick();
            check_output("t4_fill_wEn", 32'(ram_wEn), 32'h1);
            check_output("t4_fill_addr", 32'(ram_addr), 32'(i));
            check_output("t4_fill_data", 32'(ram_dataIn), 32'h07);
            check_output("t4_fill_busy", 32'(busy), 32'h1);
        end
        tick();
        check_output("t4_post_wEn", 32'(ram_wEn), 32'h1);
        check_output("t4_post_addr", 32'(ram_addr), 32'h0005);
        check_output("t4_post_data", 32'(ram_dataIn), 32'h33);
        tick();
        check_output("t4_done_wEn", 32'(ram_wEn), 32'h0);
        check_output("t4_done_busy", 32'(busy), 32'h0);

        // ---------------- 5: fill with display pauses ----------------
        $display("[TB] fill paused by active region");
        push_cmd(1'b1, 1'b0, 8'h3C, 15'h0000);
        writes        = 0;
        expected_addr = 0;
        for (int cyc = 0; cyc < 40000 && writes < 16384; cyc++) begin
            vga_active    = ((cyc / 100) % 2) == 1;
            vga_addr      = 15'(cyc);
            prev_active   = vga_active;
            prev_vga_addr = vga_addr;
            tick();
            if (prev_active) begin
                check_output("t5_no_write_active", 32'(ram_wEn), 32'h0);
                check_output("t5_read_addr", 32'(ram_addr), 32'(prev_vga_addr));
            end else if (ram_wEn) begin
                check_output("t5_fill_addr", 32'(ram_addr), 32'(expected_addr));
                check_output("t5_fill_data", 32'(ram_dataIn), 32'h3C);
                expected_addr++;
                writes++;
            end
        end
        vga_active = 1'b0;
        check_output("t5_fill_count", 32'(writes), 32'd16384);
        check_output("t5_busy_done", 32'(busy), 32'h0);
        tick();
        check_output("t5_no_extra_write", 32'(ram_wEn), 32'h0);

        // ---------------- 6: reset mid-fill ----------------
        $display("[TB] reset during fill");
        push_cmd(1'b1, 1'b0, 8'h55, 15'h0000);
        push_cmd(1'b0, 1'b1, 8'h11, 15'h7777);
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            tick();
            if (ram_wEn && ram_addr == 15'h1000) found = 1'b1;
        end
        check_output("t6_reached_0x1000", 32'(found), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check_output("t6_async_addr", 32'(ram_addr), 32'h0);
        check_output("t6_async_wEn", 32'(ram_wEn), 32'h0);
        check_output("t6_async_data", 32'(ram_dataIn), 32'h0);
        check_output("t6_busy", 32'(busy), 32'h0);
        check_output("t6_overflow_cleared", 32'(overflow), 32'h0);
        check_output("t6_ready", 32'(cpu_ready), 32'h1);
        tick();
        reset = 1'b0;
        tick();
        check_output("t6_no_stale_write", 32'(ram_wEn), 32'h0);
        push_cmd(1'b0, 1'b1, 8'h99, 15'h0042);
        check_output("t6_new_pending", 32'(ram_wEn), 32'h0);
        tick();
        check_output("t6_new_wEn", 32'(ram_wEn), 32'h1);
        check_output("t6_new_addr", 32'(ram_addr), 32'h0042);
        check_output("t6_new_data", 32'(ram_dataIn), 32'h99);
        tick();
        check_output("t6_new_done", 32'(ram_wEn), 32'h0);
        check_output("t6_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
